// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter,
// polarity-qualified edge pulse and saturating edge counter.
module edge_detect_multi #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2,
  parameter int CNT_WIDTH   = 8,
  parameter bit RST_LEVEL   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_CH-1:0]             d_in,
  input  logic [2*NUM_CH-1:0]           mode,
  input  logic                          clr_cnt,
  output logic [NUM_CH-1:0]             d_level,
  output logic [NUM_CH-1:0]             d_edge,
  output logic                          any_edge,
  output logic [NUM_CH*CNT_WIDTH-1:0]   edge_cnt,
  output logic [NUM_CH-1:0]             cnt_sat
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_PRE = CNT_MAX - CNT_WIDTH'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          filt_cnt;
    logic                   level_q;
    logic                   edge_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   sat_q;
    logic                   sync_out;
    logic                   accept;
    logic                   edge_ok;

    // Level change is accepted once the differing level has been seen FILTER_LEN times in a row.
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign accept   = (sync_out != level_q) && (filt_cnt == FILT_LAST);
    // The new level is sync_out, so its value tells the direction of the change.
    assign edge_ok  = en && (sync_out ? mode[2*i] : mode[2*i+1]);

    // Synchroniser chain; the oldest stage feeds the filter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= {SYNC_STAGES{RST_LEVEL}};
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], d_in[i]};
    end

    // Glitch filter: count consecutive disagreeing samples, toggle the level when the run is long enough.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        filt_cnt <= '0;
        level_q  <= RST_LEVEL;
      end else if (sync_out == level_q) begin
        filt_cnt <= '0;
      end else if (accept) begin
        filt_cnt <= '0;
        level_q  <= sync_out;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end

    // Edge pulse is registered alongside the level change so both appear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) edge_q <= 1'b0;
      else     edge_q <= accept && edge_ok;
    end

    // Saturating edge counter with sticky saturation flag; clear beats a coincident edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (clr_cnt) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (edge_q) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_WIDTH'(1);
        if (cnt_q == CNT_PRE) sat_q <= 1'b1;
      end
    end

    assign d_level[i] = level_q;
    assign d_edge[i]  = edge_q;
    assign cnt_sat[i] = sat_q;
    assign edge_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  assign any_edge = |d_edge;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench for edge_detect_multi: directed scenarios plus randomized traffic,
// every cycle checked against a behavioural model through a scoreboard queue.
module tb_edge_detect_multi;

  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 2;
  localparam int CNT_WIDTH   = 3;
  localparam bit RST_LEVEL   = 1'b1;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        en;
  logic [NUM_CH-1:0]           d_in;
  logic [2*NUM_CH-1:0]         mode;
  logic                        clr_cnt;
  logic [NUM_CH-1:0]           d_level;
  logic [NUM_CH-1:0]           d_edge;
  logic                        any_edge;
  logic [NUM_CH*CNT_WIDTH-1:0] edge_cnt;
  logic [NUM_CH-1:0]           cnt_sat;

  typedef struct packed {
    logic [NUM_CH-1:0]           level;
    logic [NUM_CH-1:0]           edge_v;
    logic [NUM_CH*CNT_WIDTH-1:0] cnt;
    logic [NUM_CH-1:0]           sat;
  } snap_t;

  snap_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  edge_detect_multi #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN),
    .CNT_WIDTH(CNT_WIDTH), .RST_LEVEL(RST_LEVEL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .mode(mode), .clr_cnt(clr_cnt),
    .d_level(d_level), .d_edge(d_edge), .any_edge(any_edge),
    .edge_cnt(edge_cnt), .cnt_sat(cnt_sat)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial forever #5 clk = ~clk;

  // Reference model: a new level is accepted once the last FILTER_LEN synchronised
  // samples all disagree with the current level; the synchronised sample is the
  // input seen SYNC_STAGES clock edges earlier.
  initial begin
    logic [NUM_CH-1:0] hist[$];
    logic [NUM_CH-1:0] s_hist[$];
    logic [NUM_CH-1:0] m_level, m_edge, m_sat, s_now, ne;
    int                m_cnt[NUM_CH];
    int                since;
    bit                stable;
    snap_t             sn;
    m_level = {NUM_CH{RST_LEVEL}};
    m_edge  = '0;
    m_sat   = '0;
    since   = 0;
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_level = {NUM_CH{RST_LEVEL}};
        m_edge  = '0;
        m_sat   = '0;
        for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
        hist.delete();
        for (int k = 0; k < SYNC_STAGES; k++) hist.push_back({NUM_CH{RST_LEVEL}});
        s_hist.delete();
        since = 0;
      end else begin
        s_now = hist.pop_front();
        hist.push_back(d_in);
        s_hist.push_back(s_now);
        if (s_hist.size() > FILTER_LEN) void'(s_hist.pop_front());
        since++;
        for (int c = 0; c < NUM_CH; c++) begin
          if (clr_cnt) begin
            m_cnt[c] = 0;
            m_sat[c] = 1'b0;
          end else if (m_edge[c]) begin
            if (m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
            if (m_cnt[c] == CNT_MAX) m_sat[c] = 1'b1;
          end
        end
        ne = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          stable = (since >= FILTER_LEN);
          foreach (s_hist[j]) if (s_hist[j][c] == m_level[c]) stable = 1'b0;
          if (stable) begin
            m_level[c] = ~m_level[c];
            ne[c] = en && (m_level[c] ? mode[2*c] : mode[2*c+1]);
          end
        end
        m_edge = ne;
      end
      sn.level  = m_level;
      sn.edge_v = m_edge;
      sn.sat    = m_sat;
      for (int c = 0; c < NUM_CH; c++) sn.cnt[c*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(m_cnt[c]);
      exp_q.push_back(sn);
    end
  end

  // Monitor: just after each rising edge, pop the expected snapshot and compare all outputs.
  initial forever begin
    snap_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (d_level !== e.level || d_edge !== e.edge_v || any_edge !== (|e.edge_v) ||
          edge_cnt !== e.cnt || cnt_sat !== e.sat) begin
        mismatched++;
        $display("[TB] FAIL scoreboard t=%0t: got level=%h edge=%h any=%b cnt=%h sat=%h, expected level=%h edge=%h any=%b cnt=%h sat=%h",
                 $time, d_level, d_edge, any_edge, edge_cnt, cnt_sat,
                 e.level, e.edge_v, |e.edge_v, e.cnt, e.sat);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [NUM_CH-1:0] d, input logic e,
                               input logic [2*NUM_CH-1:0] m, input logic c, input int n);
    d_in    = d;
    en      = e;
    mode    = m;
    clr_cnt = c;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [NUM_CH-1:0]   rd;
    logic [2*NUM_CH-1:0] rm;
    logic                re, rc;
    rst = 1'b1; d_in = '1; en = 1'b1; mode = '1; clr_cnt = 1'b0;
    @(posedge clk);
    #2;
    applyStimulus(4'hF, 1'b1, 8'hFF, 1'b0, 3);
    rst = 1'b0;
    applyStimulus(4'hF, 1'b1, 8'hFF, 1'b0, 20);
    checkOutput("idle level", 32'(d_level), 32'hF);
    checkOutput("idle edge", 32'(d_edge), 32'h0);
    checkOutput("idle any_edge", 32'(any_edge), 32'h0);
    checkOutput("idle counts", 32'(edge_cnt), 32'h0);
    checkOutput("idle sat", 32'(cnt_sat), 32'h0);

    // Falling edge on ch0: level must hold for 3 edges and change on the 4th.
    applyStimulus(4'hE, 1'b1, 8'hFF, 1'b0, 3);
    checkOutput("ch0 level before latency", 32'(d_level[0]), 32'h1);
    applyStimulus(4'hE, 1'b1, 8'hFF, 1'b0, 1);
    checkOutput("ch0 level at latency", 32'(d_level[0]), 32'h0);
    checkOutput("ch0 falling pulse", 32'(d_edge), 32'h1);
    applyStimulus(4'hE, 1'b1, 8'hFF, 1'b0, 1);
    checkOutput("ch0 pulse one cycle", 32'(d_edge), 32'h0);
    checkOutput("ch0 count 1", 32'(edge_cnt[0 +: CNT_WIDTH]), 32'h1);
    applyStimulus(4'hE, 1'b1, 8'hFF, 1'b0, 8);
    applyStimulus(4'hF, 1'b1, 8'hFF, 1'b0, 10);
    checkOutput("ch0 count 2", 32'(edge_cnt[0 +: CNT_WIDTH]), 32'h2);

    // Glitch on ch1: one cycle is discarded, two cycles are accepted.
    applyStimulus(4'hD, 1'b1, 8'hFF, 1'b0, 1);
    applyStimulus(4'hF, 1'b1, 8'hFF, 1'b0, 10);
    checkOutput("ch1 glitch count", 32'(edge_cnt[CNT_WIDTH +: CNT_WIDTH]), 32'h0);
    checkOutput("ch1 glitch level", 32'(d_level), 32'hF);
    applyStimulus(4'hD, 1'b1, 8'hFF, 1'b0, 2);
    applyStimulus(4'hF, 1'b1, 8'hFF, 1'b0, 10);
    checkOutput("ch1 accepted count", 32'(edge_cnt[CNT_WIDTH +: CNT_WIDTH]), 32'h2);

    // Modes: ch2 rising only, ch3 off.
    applyStimulus(4'h3, 1'b1, 8'b00_01_11_11, 1'b0, 8);
    applyStimulus(4'hF, 1'b1, 8'b00_01_11_11, 1'b0, 8);
    applyStimulus(4'h3, 1'b1, 8'b00_01_11_11, 1'b0, 8);
    checkOutput("ch2 rising-only count", 32'(edge_cnt[2*CNT_WIDTH +: CNT_WIDTH]), 32'h1);
    checkOutput("ch3 off count", 32'(edge_cnt[3*CNT_WIDTH +: CNT_WIDTH]), 32'h0);
    checkOutput("mode level tracking", 32'(d_level), 32'h3);
    applyStimulus(4'hF, 1'b1, 8'hFF, 1'b0, 8);

    // Disabled toggle on ch0, then re-enable without a stale pulse.
    applyStimulus(4'hE, 1'b0, 8'hFF, 1'b0, 8);
    checkOutput("en=0 level tracks", 32'(d_level[0]), 32'h0);
    checkOutput("en=0 count held", 32'(edge_cnt[0 +: CNT_WIDTH]), 32'h2);
    applyStimulus(4'hE, 1'b1, 8'hFF, 1'b0, 4);
    checkOutput("re-enable count", 32'(edge_cnt[0 +: CNT_WIDTH]), 32'h2);
    applyStimulus(4'hF, 1'b0, 8'hFF, 1'b0, 8);

    // Saturation: clear, then nine edges on ch0.
    applyStimulus(4'hF, 1'b1, 8'hFF, 1'b1, 1);
    for (int k = 0; k < 9; k++) applyStimulus((k % 2 == 0) ? 4'hE : 4'hF, 1'b1, 8'hFF, 1'b0, 6);
    checkOutput("ch0 saturated count", 32'(edge_cnt[0 +: CNT_WIDTH]), 32'(CNT_MAX));
    checkOutput("ch0 sat flag", 32'(cnt_sat[0]), 32'h1);
    applyStimulus(4'hF, 1'b1, 8'hFF, 1'b0, 6);

    // Clear in the same cycle as an edge pulse: count 0, pulse still seen.
    applyStimulus(4'hE, 1'b1, 8'hFF, 1'b0, 4);
    checkOutput("clr-coincident pulse", 32'(d_edge[0]), 32'h1);
    applyStimulus(4'hE, 1'b1, 8'hFF, 1'b1, 1);
    applyStimulus(4'hE, 1'b1, 8'hFF, 1'b0, 2);
    checkOutput("clr-coincident count", 32'(edge_cnt[0 +: CNT_WIDTH]), 32'h0);
    checkOutput("clr-coincident sat", 32'(cnt_sat[0]), 32'h0);

    // Asynchronous reset while ch1 has a pending filter count.
    applyStimulus(4'hC, 1'b1, 8'hFF, 1'b0, 1);
    applyStimulus(4'hE, 1'b1, 8'hFF, 1'b0, 2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset level", 32'(d_level), 32'hF);
    checkOutput("async reset edge", 32'(d_edge), 32'h0);
    checkOutput("async reset any_edge", 32'(any_edge), 32'h0);
    checkOutput("async reset counts", 32'(edge_cnt), 32'h0);
    checkOutput("async reset sat", 32'(cnt_sat), 32'h0);
    @(posedge clk);
    #2;
    applyStimulus(4'hF, 1'b1, 8'hFF, 1'b0, 2);
    rst = 1'b0;
    applyStimulus(4'hF, 1'b1, 8'hFF, 1'b0, 15);
    checkOutput("post-reset counts", 32'(edge_cnt), 32'h0);

    // Randomized traffic: sparse toggles give both glitches and accepted edges.
    rd = 4'hF;
    rm = 8'hFF;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NUM_CH; c++) if ($urandom_range(0, 5) == 0) rd[c] = ~rd[c];
      if ($urandom_range(0, 19) == 0) rm = 8'($urandom);
      re = ($urandom_range(0, 9) != 0);
      rc = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      else rst = 1'b0;
      applyStimulus(rd, re, rm, rc, 1);
    end
    rst = 1'b0;
    applyStimulus(4'hF, 1'b1, 8'hFF, 1'b0, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Parametrised multi-channel edge detector for the USB receiver front end and other slow serial inputs. Each channel has:
- a metastability synchroniser;
- a glitch filter;
- a per-channel edge-polarity mode;
- a saturating edge counter.

The counters give link-activity statistics. Single-bit d_plus edge detection is the NUM_CH=1, FILTER_LEN=1, mode=both case.

Parameters:
NUM_CH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
FILTER_LEN, 2, consecutive synchronised cycles a new level must hold before acceptance (>=1)
CNT_WIDTH, 8, width of each per-channel edge counter (>=1)
RST_LEVEL, 1, reset value of all synchroniser and level flops (USB idle J = 1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  detection enable; 0 suppresses d_edge and counting
d_in  input  NUM_CH  asynchronous channel inputs
mode  input  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
clr_cnt  input  1  synchronous clear of all counters and saturation flags
d_level  output  NUM_CH  filtered, synchronised level
d_edge  output  NUM_CH  one-cycle edge pulse, mode-qualified
any_edge  output  1  OR of d_edge
edge_cnt  output  NUM_CH*CNT_WIDTH  per-channel edge count, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
cnt_sat  output  NUM_CH  sticky flag: counter reached all-ones

Behaviour:
- Reset (rst=1, asynchronous):
  - all synchroniser flops and d_level = RST_LEVEL;
  - filter counters = 0;
  - d_edge, any_edge = 0;
  - edge_cnt = 0, cnt_sat = 0.
  - On reset release, no edge is generated while inputs sit at RST_LEVEL.
- Synchroniser: SYNC_STAGES flop chain per channel; sync output s[i] lags d_in by SYNC_STAGES cycles.
- Filter, per channel, a counter of width clog2(FILTER_LEN)+1:
  - s[i]==d_level[i]: counter cleared.
  - s[i]!=d_level[i] and counter < FILTER_LEN-1: counter increments.
  - s[i]!=d_level[i] and counter == FILTER_LEN-1: d_level toggles and counter clears.
  - A pulse shorter than FILTER_LEN synchronised cycles is discarded.
  - FILTER_LEN=1 means d_level follows s with one register.
- Latency: d_level, and d_edge if enabled, are high in the cycle after the (SYNC_STAGES+FILTER_LEN)-th rising clk edge that samples the new stable d_in. Defaults give 4 cycles.
- Edge generation: d_edge[i] is registered and asserted for exactly one cycle, the same cycle d_level[i] changes, if and only if:
  - en=1; and
  - the mode sampled at that clock edge allows the direction (01 = 0->1, 10 = 1->0, 11 = either, 00 = none).
- en=0: synchroniser and filter keep tracking (d_level stays valid); d_edge = 0; counters hold. Re-enabling never produces a stale edge.
- Counter:
  - increments by 1 on each cycle d_edge[i]=1;
  - at all-ones it holds and cnt_sat[i] is set (sticky); it never wraps.
- clr_cnt=1: all edge_cnt and cnt_sat cleared next cycle. If an edge occurs in the same cycle, clear wins: the count is 0, but d_edge still pulses.
- Channels are fully independent; simultaneous edges on several channels each pulse and count.
- Mode change takes effect for any level change accepted on or after the clock edge at which the new mode is sampled. It does not disturb the filter state.
- Reset mid-filter: the filter counter and pending level change are discarded and d_level returns to RST_LEVEL.
- any_edge is combinational OR of the registered d_edge (no added latency).

Test Plan:
- Reset release with d_in all 1, 20 cycles idle -> d_edge=0, d_level=4'hF, edge_cnt all 0, cnt_sat=0.
- Defaults, mode=11, d_in[0] 1->0 held -> d_level[0]=0 and d_edge[0]=1 for exactly one cycle, 4 cycles after the sampling edge; edge_cnt[0]=1. Return 0->1 gives edge_cnt[0]=2.
- Glitch: d_in[1] low for 1 cycle, FILTER_LEN=2 -> no d_level change, no d_edge, count 0. Low for 2 cycles -> falling edge accepted.
- Mode: ch2 mode=01 with a full 0->1->0 toggle -> one d_edge and count 1. Ch3 mode=00 -> d_level tracks, d_edge never asserts, count 0. en=0 during a toggle on ch0 -> no pulse, count held.
- Saturation, CNT_WIDTH=3: 9 edges on ch0 -> edge_cnt[0]=7 and cnt_sat[0]=1 from the 7th edge on. clr_cnt coincident with an edge -> count 0, d_edge pulse still seen.
- rst asserted asynchronously mid-filter (d_in differs for 1 cycle) -> all outputs at reset values immediately, no edge after release.
